// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter
// Round-robin arbiter and sequencer in front of one shared W-bit bitwise
// logic unit (AND/OR/XOR/NAND). One request is accepted at a time over a
// valid/ready handshake. Its operands are latched and the result is computed
// into a register. The result is then returned with the winner's ID over a
// valid/ready response channel.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   req_valid     [N_REQ]      per-requester request valid
//   req_ready     [N_REQ]      per-requester accept, one-hot or zero, IDLE only
//   req_x, req_y  [N_REQ*W]    operands, requester i at [i*W +: W]
//   req_op        [N_REQ*2]    opcode, requester i at [i*2 +: 2]
//                              (00 AND, 01 OR, 10 XOR, 11 NAND)
//   resp_valid    result available (held until resp_ready)
//   resp_ready    consumer accepts result
//   resp_data     [W]          result
//   resp_id       [ID_W]       owner of resp_data
//   busy          high whenever the sequencer is not idle
module logic_unit_arbiter #(
  parameter int W     = 4,
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*W-1:0]   req_x,
  input  logic [N_REQ*W-1:0]   req_y,
  input  logic [N_REQ*2-1:0]   req_op,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [W-1:0]         resp_data,
  output logic [ID_W-1:0]      resp_id,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [W-1:0]    x_q, x_d;
  logic [W-1:0]    y_q, y_d;
  logic [1:0]      op_q, op_d;
  logic [W-1:0]    resp_data_q, resp_data_d;
  logic [ID_W-1:0] resp_id_q, resp_id_d;

  logic            grant_any;
  logic [ID_W-1:0] win_id;
  logic [ID_W-1:0] scan_idx;
  logic [W-1:0]    win_x, win_y;
  logic [1:0]      win_op;

  function automatic logic [W-1:0] logic_op(input logic [1:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [W-1:0] r;
    case (op)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      default: r = ~(a & b);
    endcase
    return r;
  endfunction

  // Rotating priority scan: walk offsets from the highest down so the
  // closest set bit at or after rr_ptr is the last one written and wins.
  // The index wraps for free because N_REQ is a power of two.
  always_comb begin
    grant_any = 1'b0;
    win_id    = rr_ptr_q;
    scan_idx  = rr_ptr_q;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan_idx = rr_ptr_q + ID_W'(k);
      if (req_valid[scan_idx]) begin
        grant_any = 1'b1;
        win_id    = scan_idx;
      end
    end
  end

  // Operand mux for the selected requester.
  always_comb begin
    win_x  = '0;
    win_y  = '0;
    win_op = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_id == ID_W'(i)) begin
        win_x  = req_x[i*W +: W];
        win_y  = req_y[i*W +: W];
        win_op = req_op[i*2 +: 2];
      end
    end
  end

  // The accept strobe is combinational so the handshake completes on the
  // same edge that latches the operands. It is forced low during reset.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && grant_any && !rst) req_ready[win_id] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    x_d         = x_q;
    y_d         = y_q;
    op_d        = op_q;
    resp_data_d = resp_data_q;
    resp_id_d   = resp_id_q;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          x_d      = win_x;
          y_d      = win_y;
          op_d     = win_op;
          id_d     = win_id;
          rr_ptr_d = win_id + 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        resp_data_d = logic_op(op_q, x_q, y_q);
        resp_id_d   = id_q;
        state_d     = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      op_q        <= '0;
      resp_data_q <= '0;
      resp_id_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      x_q         <= x_d;
      y_q         <= y_d;
      op_q        <= op_d;
      resp_data_q <= resp_data_d;
      resp_id_q   <= resp_id_d;
    end
  end

  assign resp_valid = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Bench for logic_unit_arbiter (W=4, N_REQ=4): transaction-level reference
// model, per-cycle output comparison, and directed scenarios with literal
// expectations.
module tb_logic_unit_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_x;
  logic [15:0] req_y;
  logic [7:0]  req_op;
  logic        resp_valid;
  logic        resp_ready;
  logic [3:0]  resp_data;
  logic [1:0]  resp_id;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic_unit_arbiter #(.W(4), .N_REQ(4), .ID_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_op     (req_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase 0 = waiting, 1 = computing, 2 = presenting.
  int m_phase = 0;
  int m_rr    = 0;
  int m_x     = 0;
  int m_y     = 0;
  int m_op    = 0;
  int m_id    = 0;
  int m_data  = 0;
  int m_rid   = 0;

  function automatic int rr_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++)
      if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic int lu(input int op, input int a, input int b);
    case (op)
      0:       return a & b;
      1:       return a | b;
      2:       return a ^ b;
      default: return (~(a & b)) & 15;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_rr <= 0; m_x <= 0; m_y <= 0; m_op <= 0;
      m_id <= 0; m_data <= 0; m_rid <= 0;
    end else begin
      case (m_phase)
        0: if (rr_pick(req_valid, m_rr) >= 0) begin
          m_x     <= int'(req_x >> (4 * rr_pick(req_valid, m_rr))) & 15;
          m_y     <= int'(req_y >> (4 * rr_pick(req_valid, m_rr))) & 15;
          m_op    <= int'(req_op >> (2 * rr_pick(req_valid, m_rr))) & 3;
          m_id    <= rr_pick(req_valid, m_rr);
          m_rr    <= (rr_pick(req_valid, m_rr) + 1) % 4;
          m_phase <= 1;
        end
        1: begin
          m_data  <= lu(m_op, m_x, m_y);
          m_rid   <= m_id;
          m_phase <= 2;
        end
        default: if (resp_ready) m_phase <= 0;
      endcase
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic compare_loop();
    forever begin
      int p;
      int er;
      @(negedge clk);
      er = 0;
      if (m_phase == 0 && !rst) begin
        p = rr_pick(req_valid, m_rr);
        if (p >= 0) er = 1 << p;
      end
      check("cyc_req_ready", 32'(req_ready), 32'(er));
      check("cyc_resp_valid", 32'(resp_valid), 32'(m_phase == 2));
      check("cyc_busy", 32'(busy), 32'(m_phase != 0));
      check("cyc_resp_data", 32'(resp_data), 32'(m_data));
      check("cyc_resp_id", 32'(resp_id), 32'(m_rid));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_req(input int i, input logic [3:0] x, input logic [3:0] y,
                        input logic [1:0] op, input logic [3:0] exp_d);
    int n;
    req_x[i*4 +: 4] = x;
    req_y[i*4 +: 4] = y;
    req_op[i*2 +: 2] = op;
    req_valid[i] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[i] && n < 20) begin tick(); n++; end
    check("req_grant_timeout", 32'(n < 20), 32'd1);
    tick();
    req_valid[i] = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin tick(); n++; end
    check("req_resp_timeout", 32'(n < 20), 32'd1);
    check("req_resp_data", 32'(resp_data), 32'(exp_d));
    check("req_resp_id", 32'(resp_id), 32'(i));
    tick();
  endtask

  int gid[$];
  int gcy[$];
  int exp_ops[4] = '{4, 15, 11, 11};

  initial begin
    rst = 1'b1; req_valid = '0; req_x = '0; req_y = '0; req_op = '0; resp_ready = 1'b0;
    fork compare_loop(); join_none

    repeat (2) @(posedge clk);
    #2;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_data", 32'(resp_data), 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    rst = 1'b0;

    // Single request, requester 0: 1000 AND 1001 = 1000
    resp_ready = 1'b1;
    req_x[3:0] = 4'b1000; req_y[3:0] = 4'b1001; req_op[1:0] = 2'b00;
    req_valid = 4'b0001;
    #1;
    check("t1_req_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0000;
    check("t1_exec_busy", 32'(busy), 32'd1);
    check("t1_exec_resp_valid", 32'(resp_valid), 32'd0);
    tick();
    check("t1_resp_valid", 32'(resp_valid), 32'd1);
    check("t1_resp_data", 32'(resp_data), 32'b1000);
    check("t1_resp_id", 32'(resp_id), 32'd0);
    check("t1_resp_busy", 32'(busy), 32'd1);
    tick();
    check("t1_idle_resp_valid", 32'(resp_valid), 32'd0);
    check("t1_idle_busy", 32'(busy), 32'd0);
    check("t1_data_kept", 32'(resp_data), 32'b1000);

    // All opcodes on requester 2
    for (int op = 0; op < 4; op++)
      do_req(2, 4'b1101, 4'b0110, 2'(op), 4'(exp_ops[op]));

    // Fairness from a fresh pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("model_rr_reset", 32'(m_rr), 32'd0);
    req_x = 16'h1234; req_y = 16'h5678; req_op = 8'b11100100;
    req_valid = 4'b1111; resp_ready = 1'b1;
    #1;
    for (int c = 0; c < 15; c++) begin
      for (int b = 0; b < 4; b++)
        if (req_ready[b]) begin gid.push_back(b); gcy.push_back(c); end
      tick();
    end
    req_valid = 4'b0000;
    check("rr_grant_count", 32'(gid.size()), 32'd5);
    for (int i = 0; i < 5 && i < gid.size(); i++) begin
      check("rr_grant_order", 32'(gid[i]), 32'(i % 4));
      if (i > 0) check("rr_grant_spacing", 32'(gcy[i] - gcy[i-1]), 32'd3);
    end
    check("model_rr_wrap", 32'(m_rr), 32'd1);

    // Backpressure: requester 1, 0011 XOR 0101 = 0110
    resp_ready = 1'b0;
    req_x[7:4] = 4'b0011; req_y[7:4] = 4'b0101; req_op[3:2] = 2'b10;
    req_valid = 4'b0010;
    #1;
    check("bp_req_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b0000;
    tick();
    req_valid = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      req_x = 16'($urandom); req_y = 16'($urandom); req_op = 8'($urandom);
      #1;
      check("bp_resp_valid", 32'(resp_valid), 32'd1);
      check("bp_resp_data", 32'(resp_data), 32'b0110);
      check("bp_resp_id", 32'(resp_id), 32'd1);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      tick();
    end
    req_x[11:8] = 4'b1111; req_y[11:8] = 4'b0001; req_op[5:4] = 2'b00;
    resp_ready = 1'b1;
    tick();
    #1;
    check("bp_next_grant", 32'(req_ready), 32'b0100);
    check("bp_idle_resp_valid", 32'(resp_valid), 32'd0);
    tick();
    req_valid = 4'b0000;
    tick();
    check("bp_next_data", 32'(resp_data), 32'b0001);
    check("bp_next_id", 32'(resp_id), 32'd2);
    tick();

    // Wrap priority: pointer at 3, requesters 0 and 2 pending
    check("model_rr_at3", 32'(m_rr), 32'd3);
    req_x[3:0] = 4'b1010;  req_y[3:0] = 4'b0110;  req_op[1:0] = 2'b01;
    req_x[11:8] = 4'b1100; req_y[11:8] = 4'b1010; req_op[5:4] = 2'b10;
    req_valid = 4'b0101;
    #1;
    check("wrap_grant0", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0100;
    tick();
    check("wrap_data0", 32'(resp_data), 32'b1110);
    check("wrap_id0", 32'(resp_id), 32'd0);
    tick();
    #1;
    check("wrap_grant2", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b0000;
    tick();
    check("wrap_data2", 32'(resp_data), 32'b0110);
    check("wrap_id2", 32'(resp_id), 32'd2);
    tick();

    // Reset during EXEC
    req_x[15:12] = 4'b0111; req_y[15:12] = 4'b0011; req_op[7:6] = 2'b00;
    req_valid = 4'b1000;
    #1;
    check("mid_grant3", 32'(req_ready), 32'b1000);
    tick();
    req_valid = 4'b0000;
    check("mid_exec_busy", 32'(busy), 32'd1);
    #1;
    req_x[7:4] = 4'b1100; req_y[7:4] = 4'b1010; req_op[3:2] = 2'b11;
    req_valid = 4'b0010;
    rst = 1'b1;
    #1;
    check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_grant1", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b0000;
    tick();
    check("post_rst_data", 32'(resp_data), 32'b0111);
    check("post_rst_id", 32'(resp_id), 32'd1);
    tick();
    check("post_rst_idle", 32'(busy), 32'd0);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
